q_8_41_serializer: RTL and testbench

Downstream stage of the q_8_41 decimator. It requests each decimated word from the decimator controller by pulsing `load`, captures the `R0` output on the following cycle, and shifts it out MSB-first on a framed one-bit serial line. When the parity feature is compiled in, it appends an even-parity bit. It also keeps a wrapping count of completed frames.

---
 rtl/q_8_41_serializer.sv | 115 +++++++++++
 tb/tb_q_8_41_serializer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/q_8_41_serializer.sv
//==============================================================================
// Module      : q_8_41_serializer
// Description : Requests decimated words via a one-cycle load pulse, then sends
//               each word MSB-first on a framed serial line and counts frames.
//               Define Q_8_41_SER_PARITY_EN to append an even-parity bit.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module q_8_41_serializer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         avail,
    input  logic [W-1:0] din,
    output logic         load,
    output logic         sout,
    output logic         sframe,
    output logic         busy,
    output logic [15:0]  word_cnt
);

    localparam int              c_CW   = $clog2(W);
    localparam logic [c_CW-1:0] c_LAST = c_CW'(W - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_CAP   = 3'd2,
`ifdef Q_8_41_SER_PARITY_EN
        S_PAR   = 3'd4,
`endif
        S_SHIFT = 3'd3
    } state_t;

    state_t          r_state;
    logic [W-1:0]    r_shift;
    logic [c_CW-1:0] r_bit_cnt;
    logic [15:0]     r_word_cnt;
`ifdef Q_8_41_SER_PARITY_EN
    logic            r_par;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_word_cnt <= '0;
`ifdef Q_8_41_SER_PARITY_EN
            r_par      <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (avail) begin
                        r_state <= S_REQ;
                    end
                end
                S_REQ: begin
`ifdef Q_8_41_SER_PARITY_EN
                    r_par   <= 1'b0;
`endif
                    r_state <= S_CAP;
                end
                S_CAP: begin
                    r_shift   <= din;
                    r_bit_cnt <= c_LAST;
                    r_state   <= S_SHIFT;
                end
                S_SHIFT: begin
                    r_shift   <= {r_shift[W-2:0], 1'b0};
                    r_bit_cnt <= r_bit_cnt - c_CW'(1);
`ifdef Q_8_41_SER_PARITY_EN
                    r_par     <= r_par ^ r_shift[W-1];
                    if (r_bit_cnt == '0) begin
                        r_state <= S_PAR;
                    end
`else
                    if (r_bit_cnt == '0) begin
                        r_word_cnt <= r_word_cnt + 16'd1;
                        r_state    <= avail ? S_REQ : S_IDLE;
                    end
`endif
                end
`ifdef Q_8_41_SER_PARITY_EN
                S_PAR: begin
                    r_word_cnt <= r_word_cnt + 16'd1;
                    r_state    <= avail ? S_REQ : S_IDLE;
                end
`endif
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Outputs decode state and registers only; no input reaches an output.
    assign load     = (r_state == S_REQ);
    assign busy     = (r_state != S_IDLE);
    assign word_cnt = r_word_cnt;
`ifdef Q_8_41_SER_PARITY_EN
    assign sframe   = (r_state == S_SHIFT) || (r_state == S_PAR);
    assign sout     = ((r_state == S_SHIFT) && r_shift[W-1]) ||
                      ((r_state == S_PAR) && r_par);
`else
    assign sframe   = (r_state == S_SHIFT);
    assign sout     = (r_state == S_SHIFT) && r_shift[W-1];
`endif

endmodule

`default_nettype wire

// File: tb/tb_q_8_41_serializer.sv
// Bench for q_8_41_serializer: frame-position reference model plus directed
// literal frames, back-to-back spacing, mid-frame reset, random traffic and wrap.
`default_nettype none

module tb_q_8_41_serializer;

    localparam int W = 8;
`ifdef Q_8_41_SER_PARITY_EN
    localparam int FL = W + 1;
`else
    localparam int FL = W;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         avail = 1'b1;
    logic [W-1:0] din = '0;
    logic         load, sout, sframe, busy;
    logic [15:0]  word_cnt;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    logic [W-1:0] dq[$];

    // Reference model: ph = -1 idle, 0 request, 1 capture, 2..FL+1 frame bits
    int           ph = -1;
    logic [W-1:0] m_word = '0;
    logic [15:0]  m_cnt = '0;

    q_8_41_serializer #(.W(W)) dut (
        .clk(clk), .rst(rst), .avail(avail), .din(din),
        .load(load), .sout(sout), .sframe(sframe), .busy(busy), .word_cnt(word_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            ph    = -1;
            m_cnt = '0;
        end else if (ph == -1) begin
            if (avail) ph = 0;
        end else if (ph == 0) begin
            ph = 1;
        end else if (ph == 1) begin
            m_word = din;
            ph     = 2;
        end else if (ph == FL + 1) begin
            m_cnt = m_cnt + 16'd1;
            ph    = avail ? 0 : -1;
        end else begin
            ph++;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            logic e_sout;
            e_sout = 1'b0;
            if (ph >= 2 && ph <= W + 1) e_sout = m_word[W - 1 - (ph - 2)];
            else if (ph == W + 2)       e_sout = ^m_word;
            chk("load",     {31'd0, load},   {31'd0, ph == 0});
            chk("busy",     {31'd0, busy},   {31'd0, ph >= 0});
            chk("sframe",   {31'd0, sframe}, {31'd0, ph >= 2});
            chk("sout",     {31'd0, sout},   {31'd0, e_sout});
            chk("word_cnt", {16'd0, word_cnt}, {16'd0, m_cnt});
        end
    end

    // Decimator stand-in: R0 changes at the edge ending the load cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (load) begin
                @(posedge clk);
                #1;
                din = (dq.size() != 0) ? dq.pop_front() : W'($urandom);
            end
        end
    end

    task automatic wait_load();
        int g;
        g = 0;
        while (load !== 1'b1 && g < 60) begin
            @(negedge clk);
            g++;
        end
        if (load !== 1'b1) begin
            errors++;
            $display("FAIL wait_load: got timeout expected load pulse");
        end
    endtask

    task automatic wait_idle();
        int g;
        g = 0;
        while (busy !== 1'b0 && g < 60) begin
            @(negedge clk);
            g++;
        end
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL wait_idle: got busy expected idle");
        end
    endtask

    task automatic collect(output logic [15:0] bits, output int n);
        int g;
        bits = '0;
        n    = 0;
        g    = 0;
        while (sframe !== 1'b1 && g < 40) begin
            @(negedge clk);
            g++;
        end
        while (sframe === 1'b1 && g < 80) begin
            bits = {bits[14:0], sout};
            n++;
            @(negedge clk);
            g++;
        end
    endtask

    task automatic single_frame(input logic [W-1:0] w, input logic [15:0] exp_bits);
        logic [15:0] bits;
        int          n;
        dq.push_back(w);
        avail = 1'b1;
        wait_load();
        avail = 1'b0;
        collect(bits, n);
        chk("frame_bits", {16'd0, bits}, {16'd0, exp_bits});
        chk("frame_len",  n, FL);
    endtask

    initial begin
        logic [15:0] bits, c0;
        int          n, g, t1, nf;

        // Reset held two cycles with avail high
        @(posedge clk);
        chk_en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_load",   {31'd0, load},   32'd0);
        chk("rst_sframe", {31'd0, sframe}, 32'd0);
        chk("rst_busy",   {31'd0, busy},   32'd0);
        chk("rst_sout",   {31'd0, sout},   32'd0);
        chk("rst_cnt",    {16'd0, word_cnt}, 32'd0);
        rst = 1'b0;
        avail = 1'b0;
        @(negedge clk);
        chk("idle_load", {31'd0, load}, 32'd0);

        // Single frames with literal patterns
`ifdef Q_8_41_SER_PARITY_EN
        single_frame(8'hA5, 16'h014A);
        chk("cnt_after_a5", {16'd0, word_cnt}, 32'd1);
        wait_idle();
        single_frame(8'h07, 16'h000F);
`else
        single_frame(8'hA5, 16'h00A5);
        chk("cnt_after_a5", {16'd0, word_cnt}, 32'd1);
        wait_idle();
        single_frame(8'h07, 16'h0007);
`endif
        wait_idle();

        // Back-to-back frames
        c0 = word_cnt;
        dq.push_back(8'h3C);
        dq.push_back(8'hC3);
        avail = 1'b1;
        wait_load();
        t1 = 0;
        @(negedge clk);
        t1 = 1;
        while (load !== 1'b1 && t1 < 40) begin
            @(negedge clk);
            t1++;
        end
        chk("b2b_spacing", t1, FL + 2);
        avail = 1'b0;
        collect(bits, n);
`ifdef Q_8_41_SER_PARITY_EN
        chk("b2b_bits", {16'd0, bits}, 32'h0186);
`else
        chk("b2b_bits", {16'd0, bits}, 32'h00C3);
`endif
        chk("b2b_cnt", {16'd0, word_cnt}, {16'd0, c0 + 16'd2});
        wait_idle();

        // Reset on the 4th data bit
        avail = 1'b1;
        wait_load();
        avail = 1'b0;
        nf = 0;
        g  = 0;
        while (nf < 4 && g < 40) begin
            @(negedge clk);
            g++;
            if (sframe === 1'b1) nf++;
        end
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_sframe", {31'd0, sframe}, 32'd0);
        chk("midrst_cnt",    {16'd0, word_cnt}, 32'd0);
        rst   = 1'b0;
        avail = 1'b1;
        wait_load();
        avail = 1'b0;
        collect(bits, n);
        chk("midrst_cnt_after", {16'd0, word_cnt}, 32'd1);
        wait_idle();

        // Randomized traffic with occasional reset
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            avail = 1'($urandom_range(0, 1));
            rst   = ($urandom_range(0, 79) == 0);
        end
        @(negedge clk);
        rst   = 1'b0;
        avail = 1'b0;
        wait_idle();

        // Counter wrap
        @(negedge clk);
        force dut.r_word_cnt = 16'hFFFF;
        m_cnt = 16'hFFFF;
        @(posedge clk);
        #1;
        release dut.r_word_cnt;
        @(negedge clk);
        chk("preload_cnt", {16'd0, word_cnt}, 32'h0000FFFF);
`ifdef Q_8_41_SER_PARITY_EN
        single_frame(8'h5A, 16'h00B4);
`else
        single_frame(8'h5A, 16'h005A);
`endif
        chk("wrap_cnt", {16'd0, word_cnt}, 32'd0);
        wait_idle();
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
